decode_branch_stage: RTL and testbench

//   Receiving end of the fetch stage: the IF/ID pipeline register plus decode-stage branch resolution.
//   - Captures instructionf / pc_plus_2f each cycle.
//   - Extracts register specifiers for the register file.
//   - Resolves BEQ/BNE/JMP and returns pc_branch_d / pcsrc_d to fetch.
//   - Squashes the wrong-path instruction after a taken branch.
//   - Keeps a saturating count of taken branches.

---
 rtl/decode_branch_stage.sv | 94 +++++++++
 tb/tb_decode_branch_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_branch_stage.sv
// decode_branch_stage: IF/ID pipeline register plus decode-stage branch
// resolution. Branches resolve combinationally from the IF/ID contents and
// the forwarded operands; a taken branch squashes the fall-through slot.
module decode_branch_stage #(
  parameter logic [15:0] NOP    = 16'h0000,
  parameter logic [3:0]  OP_BEQ = 4'h4,
  parameter logic [3:0]  OP_BNE = 4'h5,
  parameter logic [3:0]  OP_JMP = 4'h6,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instructionf,
  input  logic [15:0]      pc_plus_2f,
  input  logic             stalld,
  input  logic [15:0]      rd1_d,
  input  logic [15:0]      rd2_d,
  output logic [15:0]      instrd,
  output logic [15:0]      pc_plus_2d,
  output logic             validd,
  output logic [2:0]       rs_d,
  output logic [2:0]       rt_d,
  output logic             branch_d,
  output logic [15:0]      pc_branch_d,
  output logic             pcsrc_d,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [3:0]  opcode;
  logic        is_beq;
  logic        is_bne;
  logic        is_jmp;
  logic        operands_equal;
  logic        taken;
  logic [15:0] branch_offset;

  assign rs_d = instrd[11:9];
  assign rt_d = instrd[8:6];

  // Decode the held instruction and resolve branch direction and target.
  always_comb begin
    // NOTE: every signal gets a value before any conditional override, so no
    // path through this block can leave one unassigned and infer a latch.
    opcode         = instrd[15:12];
    is_beq         = (opcode == OP_BEQ);
    is_bne         = (opcode == OP_BNE);
    is_jmp         = (opcode == OP_JMP);
    operands_equal = (rd1_d == rd2_d);
    branch_offset  = {{9{instrd[5]}}, instrd[5:0], 1'b0};
    if (is_jmp) begin
      branch_offset = {{3{instrd[11]}}, instrd[11:0], 1'b0};
    end
    // Modulo-2^16 add: wrap-around in either direction is intentional.
    pc_branch_d = pc_plus_2d + branch_offset;
    taken       = (is_beq & operands_equal) | (is_bne & ~operands_equal) | is_jmp;
    branch_d    = validd & (is_beq | is_bne);
    // A stalled branch is still waiting on forwarded operands, so it must not
    // redirect until the stall lifts; it then redirects exactly once.
    pcsrc_d     = validd & taken & ~stalld;
  end

  // IF/ID register: stall holds, taken branch squashes, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      instrd     <= NOP;
      pc_plus_2d <= '0;
      validd     <= 1'b0;
    end else if (stalld) begin
      instrd     <= instrd;
      pc_plus_2d <= pc_plus_2d;
      validd     <= validd;
    end else if (pcsrc_d) begin
      instrd     <= NOP;
      pc_plus_2d <= pc_plus_2f;
      validd     <= 1'b0;
    end else begin
      instrd     <= instructionf;
      pc_plus_2d <= pc_plus_2f;
      validd     <= 1'b1;
    end
  end

  // Saturating count of redirects actually sent to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (pcsrc_d && (taken_cnt != {CNT_W{1'b1}})) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_branch_stage.sv
// tb_decode_branch_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the IF/ID register and branch rules. The
// counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_decode_branch_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      instructionf;
  logic [15:0]      pc_plus_2f;
  logic             stalld;
  logic [15:0]      rd1_d;
  logic [15:0]      rd2_d;
  logic [15:0]      instrd;
  logic [15:0]      pc_plus_2d;
  logic             validd;
  logic [2:0]       rs_d;
  logic [2:0]       rt_d;
  logic             branch_d;
  logic [15:0]      pc_branch_d;
  logic             pcsrc_d;
  logic [CNT_W-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_valid;
  int          m_cnt;
  logic        exp_pcsrc;
  logic        exp_branch;
  logic [15:0] exp_target;

  decode_branch_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instructionf (instructionf),
    .pc_plus_2f   (pc_plus_2f),
    .stalld       (stalld),
    .rd1_d        (rd1_d),
    .rd2_d        (rd2_d),
    .instrd       (instrd),
    .pc_plus_2d   (pc_plus_2d),
    .validd       (validd),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .branch_d     (branch_d),
    .pc_branch_d  (pc_branch_d),
    .pcsrc_d      (pcsrc_d),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_instr = 16'h0000;
    m_pc    = 16'h0000;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  // Expected combinational outputs from the model state and current inputs.
  task automatic model_comb();
    int op;
    int off;
    bit taken;
    op = int'(m_instr[15:12]);
    if (op == 6) begin
      off = int'(m_instr[11:0]);
      if (off >= 2048) off -= 4096;
    end else begin
      off = int'(m_instr[5:0]);
      if (off >= 32) off -= 64;
    end
    exp_target = 16'((int'(m_pc) + 2 * off) & 'hFFFF);
    taken = (op == 4 && rd1_d == rd2_d) || (op == 5 && rd1_d != rd2_d) || (op == 6);
    exp_pcsrc  = m_valid && taken && !stalld;
    exp_branch = m_valid && (op == 4 || op == 5);
  endtask

  task automatic drive(input logic [15:0] instr, input logic [15:0] pc,
                       input logic stall, input logic [15:0] a, input logic [15:0] b);
    instructionf = instr;
    pc_plus_2f   = pc;
    stalld       = stall;
    rd1_d        = a;
    rd2_d        = b;
    #2;
    model_comb();
  endtask

  // One clock edge: the model advances with the inputs seen before the edge.
  task automatic tick();
    model_comb();
    @(posedge clk);
    if (!stalld) begin
      if (exp_pcsrc) begin
        m_instr = 16'h0000;
        m_valid = 1'b0;
      end else begin
        m_instr = instructionf;
        m_valid = 1'b1;
      end
      m_pc = pc_plus_2f;
    end
    if (exp_pcsrc && m_cnt < CNT_MAX) m_cnt++;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (instrd !== 16'h0000 || validd !== 1'b0 || pc_plus_2d !== 16'h0000 ||
        taken_cnt !== '0 || pcsrc_d !== 1'b0 || branch_d !== 1'b0) begin
      $display("FAIL reset_state: instrd=%h validd=%b pc=%h cnt=%0d pcsrc=%b branch=%b, expected all zero",
               instrd, validd, pc_plus_2d, taken_cnt, pcsrc_d, branch_d);
      errors++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(16'h1234, 16'h0010, 1'b0, 16'h0, 16'h0);
    tick();
    #2;
    checks++;
    if (instrd !== 16'h1234 || pc_plus_2d !== 16'h0010 || validd !== 1'b1) begin
      $display("FAIL reset_release: instrd=%h pc=%h validd=%b, expected 1234 0010 1",
               instrd, pc_plus_2d, validd);
      errors++;
    end
  endtask

  task automatic test_beq();
    drive(16'h4005, 16'h0020, 1'b0, 16'h0, 16'h0);
    tick();
    drive(16'h1111, 16'h0022, 1'b0, 16'd7, 16'd7);
    checks++;
    if (pcsrc_d !== 1'b1 || pc_branch_d !== 16'h002A || branch_d !== 1'b1) begin
      $display("FAIL beq_taken: pcsrc=%b target=%h branch=%b, expected 1 002A 1",
               pcsrc_d, pc_branch_d, branch_d);
      errors++;
    end
    tick();
    checks++;
    if (instrd !== 16'h0000 || validd !== 1'b0 || taken_cnt !== 4'd1) begin
      $display("FAIL beq_squash: instrd=%h validd=%b cnt=%0d, expected 0000 0 1",
               instrd, validd, taken_cnt);
      errors++;
    end
  endtask

  task automatic test_bne();
    drive(16'h503E, 16'h0020, 1'b0, 16'd3, 16'd3);
    tick();
    drive(16'h1ABC, 16'h0022, 1'b0, 16'd3, 16'd3);
    checks++;
    if (pcsrc_d !== 1'b0) begin
      $display("FAIL bne_not_taken: pcsrc=%b, expected 0", pcsrc_d);
      errors++;
    end
    tick();
    checks++;
    if (instrd !== 16'h1ABC || validd !== 1'b1 || pc_plus_2d !== 16'h0022) begin
      $display("FAIL bne_fallthrough: instrd=%h validd=%b pc=%h, expected 1ABC 1 0022",
               instrd, validd, pc_plus_2d);
      errors++;
    end
    drive(16'h503E, 16'h0020, 1'b0, 16'd1, 16'd2);
    tick();
    drive(16'h1ABC, 16'h0022, 1'b0, 16'd1, 16'd2);
    checks++;
    if (pcsrc_d !== 1'b1 || pc_branch_d !== 16'h001C) begin
      $display("FAIL bne_taken: pcsrc=%b target=%h, expected 1 001C", pcsrc_d, pc_branch_d);
      errors++;
    end
    tick();
  endtask

  task automatic test_jmp_wrap();
    drive(16'h6001, 16'hFFFE, 1'b0, 16'h0, 16'h0);
    tick();
    drive(16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);
    checks++;
    if (pcsrc_d !== 1'b1 || pc_branch_d !== 16'h0000 || branch_d !== 1'b0) begin
      $display("FAIL jmp_wrap: pcsrc=%b target=%h branch=%b, expected 1 0000 0",
               pcsrc_d, pc_branch_d, branch_d);
      errors++;
    end
    tick();
  endtask

  task automatic test_stall();
    drive(16'h4005, 16'h0030, 1'b0, 16'd5, 16'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(16'h2222, 16'h0032, 1'b1, 16'd5, 16'd5);
      checks++;
      if (pcsrc_d !== 1'b0 || instrd !== 16'h4005 || pc_plus_2d !== 16'h0030) begin
        $display("FAIL stall_hold[%0d]: pcsrc=%b instrd=%h pc=%h, expected 0 4005 0030",
                 i, pcsrc_d, instrd, pc_plus_2d);
        errors++;
      end
      tick();
    end
    drive(16'h2222, 16'h0032, 1'b0, 16'd5, 16'd5);
    checks++;
    if (pcsrc_d !== 1'b1 || pc_branch_d !== 16'h003A) begin
      $display("FAIL stall_release: pcsrc=%b target=%h, expected 1 003A", pcsrc_d, pc_branch_d);
      errors++;
    end
    tick();
    #1;
    checks++;
    if (pcsrc_d !== 1'b0 || validd !== 1'b0) begin
      $display("FAIL stall_once: pcsrc=%b validd=%b, expected 0 0", pcsrc_d, validd);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    drive(16'h4000, 16'h0040, 1'b0, 16'd1, 16'd1);
    tick();
    drive(16'h6005, 16'h0042, 1'b0, 16'd1, 16'd1);
    checks++;
    if (pcsrc_d !== 1'b1 || pc_branch_d !== 16'h0040) begin
      $display("FAIL b2b_first: pcsrc=%b target=%h, expected 1 0040", pcsrc_d, pc_branch_d);
      errors++;
    end
    tick();
    drive(16'h1000, 16'h0044, 1'b0, 16'd1, 16'd1);
    checks++;
    if (pcsrc_d !== 1'b0 || validd !== 1'b0 || instrd !== 16'h0000) begin
      $display("FAIL b2b_second: pcsrc=%b validd=%b instrd=%h, expected 0 0 0000",
               pcsrc_d, validd, instrd);
      errors++;
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 4'h4;
        1:       op = 4'h5;
        2:       op = 4'h6;
        default: op = 4'($urandom_range(0, 15));
      endcase
      drive({op, 12'($urandom)}, 16'($urandom), ($urandom_range(0, 4) == 0),
            16'($urandom_range(0, 2)), 16'($urandom_range(0, 2)));
      checks++;
      if (instrd !== m_instr || pc_plus_2d !== m_pc || validd !== m_valid ||
          rs_d !== m_instr[11:9] || rt_d !== m_instr[8:6]) begin
        $display("FAIL rand_regs[%0d]: instrd=%h pc=%h v=%b rs=%0d rt=%0d, expected %h %h %b",
                 i, instrd, pc_plus_2d, validd, rs_d, rt_d, m_instr, m_pc, m_valid);
        errors++;
      end
      checks++;
      if (pcsrc_d !== exp_pcsrc || branch_d !== exp_branch ||
          int'(taken_cnt) != m_cnt || (exp_pcsrc && pc_branch_d !== exp_target)) begin
        $display("FAIL rand_branch[%0d]: pcsrc=%b branch=%b target=%h cnt=%0d, expected %b %b %h %0d",
                 i, pcsrc_d, branch_d, pc_branch_d, taken_cnt, exp_pcsrc, exp_branch,
                 exp_target, m_cnt);
        errors++;
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 100 && m_cnt < CNT_MAX - 1; i++) begin
      drive(16'h6000, 16'($urandom), 1'b0, 16'h0, 16'h0);
      tick();
      drive(16'h1000, 16'h0000, 1'b0, 16'h0, 16'h0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(16'h6000, 16'h0100, 1'b0, 16'h0, 16'h0);
      tick();
      drive(16'h1000, 16'h0102, 1'b0, 16'h0, 16'h0);
      tick();
      checks++;
      if (taken_cnt !== 4'(CNT_MAX)) begin
        $display("FAIL cnt_saturate[%0d]: cnt=%0d, expected %0d", i, taken_cnt, CNT_MAX);
        errors++;
      end
    end
    // Reset asynchronously in the middle of a stalled cycle.
    drive(16'h6000, 16'h0200, 1'b0, 16'h0, 16'h0);
    tick();
    stalld = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (taken_cnt !== '0 || validd !== 1'b0 || instrd !== 16'h0000 || pcsrc_d !== 1'b0) begin
      $display("FAIL async_reset: cnt=%0d validd=%b instrd=%h pcsrc=%b, expected 0 0 0000 0",
               taken_cnt, validd, instrd, pcsrc_d);
      errors++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stalld = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    instructionf = 16'h0000;
    pc_plus_2f   = 16'h0000;
    stalld       = 1'b0;
    rd1_d        = 16'h0000;
    rd2_d        = 16'h0000;
    model_reset();
    #12;
    test_reset();
    test_beq();
    test_bne();
    test_jmp_wrap();
    test_stall();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
